// File: rtl/pixel_stream_sink_if.sv
// Pixel stream and frame-buffer write port bundle for pixel_stream_sink.
// slave is the sink side; master is the source / frame-buffer side.
interface pixel_stream_sink_if #(
  parameter int RBG_SIZE   = 24,
  parameter int ADDR_WIDTH = 19
);
  logic                  valid;
  logic                  ready;
  logic [RBG_SIZE-1:0]   colour_i;
  logic                  first;
  logic                  last_x;
  logic                  last_y;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [RBG_SIZE-1:0]   wr_data;
  logic                  wr_stall;

  modport slave (
    input  valid, colour_i, first, last_x, last_y, wr_stall,
    output ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output valid, colour_i, first, last_x, last_y, wr_stall,
    input  ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/pixel_stream_sink.sv
// Pixel stream sink: regenerates x/y, checks framing, writes pixels through a 2-entry skid buffer.
// Define PIXEL_SINK_STATS_EN to add saturating frame_count / err_count outputs.
module pixel_stream_sink #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int RBG_SIZE      = 24,
  parameter int ADDR_WIDTH    = 19
`ifdef PIXEL_SINK_STATS_EN
  ,
  parameter int CNT_WIDTH     = 16
`endif
) (
  input  logic clk,
  input  logic reset,
  pixel_stream_sink_if.slave bus,
  output logic frame_done,
  output logic sync_err
`ifdef PIXEL_SINK_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] err_count
`endif
);

  localparam int XW = (SCREEN_WIDTH  > 1) ? $clog2(SCREEN_WIDTH)  : 1;
  localparam int YW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(SCREEN_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_HEIGHT - 1);
  localparam logic ONE_PIXEL = (SCREEN_WIDTH == 1) && (SCREEN_HEIGHT == 1);
  // Position right after pixel (0,0); a one-pixel-wide screen goes straight to line 1.
  localparam logic [XW-1:0] X_START = (SCREEN_WIDTH == 1) ? '0 : XW'(1);
  localparam logic [YW-1:0] Y_START = ((SCREEN_WIDTH == 1) && (SCREEN_HEIGHT > 1)) ? YW'(1) : '0;

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  state_t                state, state_n;
  logic [XW-1:0]         x, x_n;
  logic [YW-1:0]         y, y_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;

  logic [1:0]            occ, occ_n;
  logic                  ready_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] e0_addr, e1_addr;
  logic [RBG_SIZE-1:0]   e0_data, e1_data;
  logic                  e0_eof, e1_eof;

  logic                  beat, push, pop, push_eof, err;
  logic                  exp_lx, exp_ly;
  logic [ADDR_WIDTH-1:0] push_addr;

  assign beat   = bus.valid && ready_q;
  assign pop    = wr_en_q && !bus.wr_stall;
  assign exp_lx = (x == X_LAST);
  assign exp_ly = exp_lx && (y == Y_LAST);

  // Beat decode: framing check and next position
  always_comb begin
    push      = 1'b0;
    push_addr = addr;
    push_eof  = 1'b0;
    err       = 1'b0;
    state_n   = state;
    x_n       = x;
    y_n       = y;
    addr_n    = addr;
    if (beat) begin
      if (bus.first) begin
        push      = 1'b1;
        push_addr = '0;
        push_eof  = ONE_PIXEL;
        err       = (state == ACTIVE);
        x_n       = X_START;
        y_n       = Y_START;
        addr_n    = ADDR_WIDTH'(1);
        state_n   = ONE_PIXEL ? WAIT_SOF : ACTIVE;
      end else if (state == ACTIVE) begin
        if ((bus.last_x == exp_lx) && (bus.last_y == exp_ly)) begin
          push     = 1'b1;
          push_eof = exp_ly;
          if (exp_ly) begin
            state_n = WAIT_SOF;
            x_n     = '0;
            y_n     = '0;
            addr_n  = '0;
          end else if (exp_lx) begin
            x_n    = '0;
            y_n    = y + YW'(1);
            addr_n = addr + ADDR_WIDTH'(1);
          end else begin
            x_n    = x + XW'(1);
            addr_n = addr + ADDR_WIDTH'(1);
          end
        end else begin
          err     = 1'b1;
          state_n = WAIT_SOF;
          x_n     = '0;
          y_n     = '0;
          addr_n  = '0;
        end
      end
    end
  end

  assign occ_n = occ + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= WAIT_SOF;
      x        <= '0;
      y        <= '0;
      addr     <= '0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_n;
      x        <= x_n;
      y        <= y_n;
      addr     <= addr_n;
      sync_err <= err;
    end
  end

  // Skid buffer: head entry drives the write port, so it is cleared by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ        <= 2'd0;
      ready_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      frame_done <= 1'b0;
      e0_addr    <= '0;
      e0_data    <= '0;
      e0_eof     <= 1'b0;
    end else begin
      occ        <= occ_n;
      ready_q    <= (occ_n != 2'd2);
      wr_en_q    <= (occ_n != 2'd0);
      frame_done <= pop && e0_eof;
      if (pop && (occ == 2'd2)) begin
        e0_addr <= e1_addr;
        e0_data <= e1_data;
        e0_eof  <= e1_eof;
      end else if (push && ((occ == 2'd0) || (pop && (occ == 2'd1)))) begin
        e0_addr <= push_addr;
        e0_data <= bus.colour_i;
        e0_eof  <= push_eof;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && (((occ == 2'd1) && !pop) || ((occ == 2'd2) && pop))) begin
      e1_addr <= push_addr;
      e1_data <= bus.colour_i;
      e1_eof  <= push_eof;
    end
  end

  assign bus.ready   = ready_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = e0_addr;
  assign bus.wr_data = e0_data;

`ifdef PIXEL_SINK_STATS_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      if (frame_done) frame_count <= sat_inc(frame_count);
      if (sync_err)   err_count   <= sat_inc(err_count);
    end
  end
`endif

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Directed bench for pixel_stream_sink on a 4x3 screen: vector table plus stall and reset sequences.
module tb_pixel_stream_sink;

  logic clk;
  logic rst;
  logic frame_done;
  logic sync_err;
`ifdef PIXEL_SINK_STATS_EN
  logic [15:0] frame_count;
  logic [15:0] err_count;
`endif

  pixel_stream_sink_if #(.RBG_SIZE(24), .ADDR_WIDTH(4)) bus ();

  pixel_stream_sink #(
    .SCREEN_WIDTH (4),
    .SCREEN_HEIGHT(3),
    .RBG_SIZE     (24),
    .ADDR_WIDTH   (4)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .bus        (bus),
    .frame_done (frame_done),
    .sync_err   (sync_err)
`ifdef PIXEL_SINK_STATS_EN
    ,
    .frame_count(frame_count),
    .err_count  (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v, f, lx, ly;
    logic [23:0] c;
    logic        st;
    logic        er, ew;
    logic [3:0]  ea;
    logic [23:0] ed;
    logic        efd, eerr;
  } vec_t;

  vec_t        vecs[$];
  logic [27:0] wq[$];
  int          fd_cnt = 0;
  int          err_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Write-port and pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_en && !bus.wr_stall) wq.push_back({bus.wr_addr, bus.wr_data});
      if (frame_done) fd_cnt++;
      if (sync_err)   err_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic f, input logic lx, input logic ly,
                     input logic [23:0] c, input logic st, input logic er, input logic ew,
                     input logic [3:0] ea, input logic [23:0] ed, input logic efd, input logic eerr);
    vec_t r;
    r.v = v; r.f = f; r.lx = lx; r.ly = ly; r.c = c; r.st = st;
    r.er = er; r.ew = ew; r.ea = ea; r.ed = ed; r.efd = efd; r.eerr = eerr;
    vecs.push_back(r);
  endtask

  // Correctly framed beats lo..hi of a 4x3 frame, each written on the next edge
  task automatic add_beats(input logic [23:0] base, input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      add(1'b1, i == 0, (i % 4) == 3, i == 11, base + 24'(i), 1'b0,
          1'b1, 1'b1, 4'(i), base + 24'(i), 1'b0, 1'b0);
  endtask

  task automatic add_tail();
    add(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 4'h0, 24'h0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 4'h0, 24'h0, 1'b0, 1'b0);
  endtask

  task automatic drive_pix(input int i, input logic [23:0] c);
    bus.valid    = 1'b1;
    bus.first    = (i == 0);
    bus.last_x   = ((i % 4) == 3);
    bus.last_y   = (i == 11);
    bus.colour_i = c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   bi;
    logic acc;
    int   wbase, fdb, erb;

    // Pre-SOF junk then a full frame
    add(1'b1, 1'b0, 1'b0, 1'b0, 24'hAA0000, 1'b0, 1'b1, 1'b0, 4'h0, 24'h0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 24'hAA0001, 1'b0, 1'b1, 1'b0, 4'h0, 24'h0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 24'hAA0002, 1'b0, 1'b1, 1'b0, 4'h0, 24'h0, 1'b0, 1'b0);
    add_beats(24'h100000, 0, 11);
    add_tail();
    // Early last_x at x=2: error, then discard until first
    add_beats(24'h200000, 0, 1);
    add(1'b1, 1'b0, 1'b1, 1'b0, 24'h2000FF, 1'b0, 1'b1, 1'b0, 4'h0, 24'h0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 24'h2000F0, 1'b0, 1'b1, 1'b0, 4'h0, 24'h0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 24'h2000F1, 1'b0, 1'b1, 1'b0, 4'h0, 24'h0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 24'h2000F2, 1'b0, 1'b1, 1'b0, 4'h0, 24'h0, 1'b0, 1'b0);
    // Restart with first at x=1,y=1, then the new frame completes
    add_beats(24'h600000, 0, 4);
    add(1'b1, 1'b1, 1'b0, 1'b0, 24'h7000AA, 1'b0, 1'b1, 1'b1, 4'h0, 24'h7000AA, 1'b0, 1'b1);
    add_beats(24'h700000, 1, 11);
    add_tail();

    rst          = 1'b1;
    bus.valid    = 1'b0;
    bus.first    = 1'b0;
    bus.last_x   = 1'b0;
    bus.last_y   = 1'b0;
    bus.colour_i = 24'h0;
    bus.wr_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus.ready, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_sync_err", sync_err, 0);
`ifdef PIXEL_SINK_STATS_EN
    chk("rst_frame_count", frame_count, 0);
    chk("rst_err_count", err_count, 0);
`endif
    rst = 1'b0;
    step();
    chk("post_rst_ready", bus.ready, 1);
    chk("post_rst_wr_en", bus.wr_en, 0);

    foreach (vecs[k]) begin
      bus.valid    = vecs[k].v;
      bus.first    = vecs[k].f;
      bus.last_x   = vecs[k].lx;
      bus.last_y   = vecs[k].ly;
      bus.colour_i = vecs[k].c;
      bus.wr_stall = vecs[k].st;
      step();
      chk($sformatf("vec%0d_ready", k), bus.ready, vecs[k].er);
      chk($sformatf("vec%0d_wr_en", k), bus.wr_en, vecs[k].ew);
      if (vecs[k].ew) begin
        chk($sformatf("vec%0d_wr_addr", k), bus.wr_addr, vecs[k].ea);
        chk($sformatf("vec%0d_wr_data", k), bus.wr_data, vecs[k].ed);
      end
      chk($sformatf("vec%0d_frame_done", k), frame_done, vecs[k].efd);
      chk($sformatf("vec%0d_sync_err", k), sync_err, vecs[k].eerr);
    end
`ifdef PIXEL_SINK_STATS_EN
    chk("table_frame_count", frame_count, 2);
    chk("table_err_count", err_count, 2);
`endif

    // Five-cycle stall during streaming
    wbase = wq.size();
    fdb   = fd_cnt;
    erb   = err_cnt;
    bi    = 0;
    for (int c = 0; c < 40; c++) begin
      if (bi < 12) drive_pix(bi, 24'h300000 + 24'(bi));
      else bus.valid = 1'b0;
      bus.wr_stall = (c >= 1) && (c <= 5);
      acc = bus.valid && bus.ready;
      step();
      if (acc) bi++;
      if (c == 1) chk("stall_ready_drop", bus.ready, 0);
      if ((c >= 1) && (c <= 5)) begin
        chk($sformatf("stall%0d_wr_en", c), bus.wr_en, 1);
        chk($sformatf("stall%0d_wr_addr", c), bus.wr_addr, 0);
        chk($sformatf("stall%0d_wr_data", c), bus.wr_data, 24'h300000);
      end
      if (c == 6) chk("stall_ready_back", bus.ready, 1);
    end
    chk("stall_write_count", wq.size() - wbase, 12);
    for (int i = 0; i < 12; i++)
      if (wbase + i < wq.size())
        chk($sformatf("stall_write%0d", i), wq[wbase + i], {4'(i), 24'h300000 + 24'(i)});
    chk("stall_frame_done_count", fd_cnt - fdb, 1);
    chk("stall_sync_err_count", err_cnt - erb, 0);
`ifdef PIXEL_SINK_STATS_EN
    chk("stall_frame_count", frame_count, 3);
`endif

    // Reset mid-frame with two entries buffered (addr 5 at head)
    for (int c = 0; c < 7; c++) begin
      drive_pix(c, 24'h400000 + 24'(c));
      bus.wr_stall = (c == 6);
      step();
    end
    chk("pre_rst_wr_en", bus.wr_en, 1);
    chk("pre_rst_wr_addr", bus.wr_addr, 5);
    chk("pre_rst_wr_data", bus.wr_data, 24'h400005);
    chk("pre_rst_ready", bus.ready, 0);
    bus.valid = 1'b0;
    fdb = fd_cnt;
    erb = err_cnt;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_wr_en", bus.wr_en, 0);
    chk("midrst_ready", bus.ready, 0);
    chk("midrst_wr_addr", bus.wr_addr, 0);
    step();
    step();
    rst          = 1'b0;
    bus.wr_stall = 1'b0;
    step();
    chk("rel_ready", bus.ready, 1);
    chk("rel_wr_en", bus.wr_en, 0);
`ifdef PIXEL_SINK_STATS_EN
    chk("rel_frame_count", frame_count, 0);
    chk("rel_err_count", err_count, 0);
`endif
    for (int c = 2; c < 4; c++) begin
      drive_pix(c, 24'h4000F0 + 24'(c));
      step();
      chk($sformatf("rel_drop%0d_wr_en", c), bus.wr_en, 0);
      chk($sformatf("rel_drop%0d_sync_err", c), sync_err, 0);
    end
    drive_pix(0, 24'h500000);
    step();
    chk("rel_sof_wr_en", bus.wr_en, 1);
    chk("rel_sof_wr_addr", bus.wr_addr, 0);
    chk("rel_sof_wr_data", bus.wr_data, 24'h500000);
    bus.valid = 1'b0;
    step();
    chk("rel_frame_done_count", fd_cnt - fdb, 0);
    chk("rel_sync_err_count", err_cnt - erb, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_stream_sink.md
# pixel_stream_sink

Receiving end of the pixel stream emitted by the pixel coordinate generator. Accepts colour beats under a valid/ready handshake with `first`/`last_x`/`last_y` framing flags. Regenerates x/y locally and checks framing against SCREEN_WIDTH×SCREEN_HEIGHT. Writes each correctly framed pixel to a linear frame-buffer write port through a 2-entry skid buffer.

## Interface
- SCREEN_WIDTH, 640, pixels per line
- SCREEN_HEIGHT, 480, lines per frame
- RBG_SIZE, 24, colour width
- ADDR_WIDTH, 19, frame-buffer address width; must satisfy 2^ADDR_WIDTH ≥ W·H
- CNT_WIDTH, 16, statistics counter width (used only with the macro)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- valid  in  1  upstream beat valid
- ready  out  1  sink can accept a beat
- colour_i  in  RBG_SIZE  pixel colour
- first  in  1  beat is pixel (0,0) of a frame
- last_x  in  1  beat is last pixel of a line
- last_y  in  1  beat is last pixel of a frame; set together with last_x
- wr_en  out  1  write request; head entry valid
- wr_addr  out  ADDR_WIDTH  linear address y·W+x
- wr_data  out  RBG_SIZE  colour to write
- wr_stall  in  1  frame buffer cannot complete a write this cycle
- frame_done  out  1  one-cycle pulse when a frame's final write completes
- sync_err  out  1  one-cycle pulse on a framing violation
- frame_count  out  CNT_WIDTH  completed frames (macro only)
- err_count  out  CNT_WIDTH  framing errors (macro only)

## Operation
- Beat transfer: valid && ready at a rising edge.
- Write completion: wr_en && !wr_stall at a rising edge. The head entry pops.
- Skid buffer: 2 entries of {addr, colour, eof}.
- ready = (occupancy < 2), driven from a register only. No combinational path from wr_stall or valid to ready.
- Accept and pop in the same cycle: occupancy unchanged.

States:
- WAIT_SOF (reset state):
  - Beats with first=0 are consumed and discarded; no write, no error.
  - A beat with first=1 is pixel (0,0): enqueue at addr 0, set x=1 (or advance per flags), go ACTIVE.
- ACTIVE: on each beat, check the flags.
  - Expected flags: first=0; last_x=(x==W-1); last_y=(x==W-1 && y==H-1).
  - Match: enqueue at the current addr, then addr+1.
    - x wraps to 0 and y increments on last_x.
    - A last_y beat is enqueued with eof=1; return to WAIT_SOF.
  - Mismatch with first=0: sync_err pulse; beat dropped; go WAIT_SOF.
  - Mismatch with first=1 (restart mid-frame): sync_err pulse; beat taken as pixel (0,0) of a new frame; stay ACTIVE.
- Address arithmetic: an incremental addr counter, reset to 0 on each accepted first beat. No multiplier.
- frame_done pulses in the cycle after a write with eof=1 completes.
- A W=1 or H=1 configuration is legal. Flags may coincide with first on the same beat.

## Timing
- Reset values: ready=0 while reset is asserted, 1 from the first cycle after release. wr_en=0, wr_addr=0, wr_data=0, frame_done=0, sync_err=0, counts=0. State=WAIT_SOF; occupancy=0; x=y=addr=0.
- Latency: a beat accepted at edge N has wr_en=1 with its addr/data from edge N (visible in cycle N+1), assuming the buffer was empty.
- Throughput: 1 pixel/cycle sustained while wr_stall=0.
- Stall: wr_en, wr_addr and wr_data stay stable while wr_stall=1. ready drops the cycle after occupancy reaches 2.
- sync_err is asserted in the cycle after the offending beat's accepting edge.
- Reset mid-frame: buffer flushed, pending writes lost, no frame_done or sync_err generated.

## Configuration
- PIXEL_SINK_STATS_EN defined:
  - frame_count increments on each frame_done.
  - err_count increments on each sync_err.
  - Both saturate at 2^CNT_WIDTH−1 and are cleared only by reset.
- Undefined: frame_count and err_count ports and their logic are absent. All other behaviour is identical.

## Test plan
- Full frame, W=4, H=3, valid always high, wr_stall=0, flags correct:
  - writes addr 0..11 with matching colours on consecutive cycles;
  - single frame_done the cycle after addr 11 completes;
  - frame_count=1.
- Beats before SOF: three first=0 beats, then a correct frame. The first three produce no write and no sync_err; the frame is written from addr 0.
- Early last_x at x=2 on line 0 (W=4):
  - sync_err pulses once and the beat is not written;
  - the following beats are discarded until first=1;
  - err_count=1.
- first=1 arriving at x=1,y=1: sync_err pulses; that beat is written at addr 0; the subsequent frame completes normally with frame_done.
- wr_stall held high for 5 cycles during streaming:
  - ready falls after two beats are buffered;
  - wr_addr/wr_data are held stable;
  - no beat is lost or duplicated after release.
- Reset asserted mid-frame at addr 5 with 2 entries buffered:
  - wr_en=0 and ready=0 immediately;
  - after release, beats without first are dropped;
  - the next frame starts at addr 0.
